// File: rtl/ir_conv_sequencer.sv
// IR load/tap-sweep sequencer for 4 dual-port IR banks; optional overrun counter via IR_OVERRUN_COUNT_EN.
// Latency: write 1 cycle after load handshake; tap_valid READ_LATENCY cycles after each sweep address.
// Backpressure: load_ready is high only while LOAD still needs samples; ticks outside READY are dropped.
module ir_conv_sequencer #(
  parameter int MEMORY_DEPTH = 6000,
  parameter int READ_LATENCY = 2
) (
  input  logic               audio_clk,
  input  logic               rst_in,
  input  logic               load_start,
  input  logic signed [15:0] load_data,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic               sample_tick,
  output logic [14:0]        ir_sample_index,
  output logic signed [15:0] write_data,
  output logic               write_enable,
  output logic [12:0]        first_ir_index,
  output logic [12:0]        second_ir_index,
  output logic               tap_valid,
  output logic [12:0]        tap_index,
  output logic               sweep_done,
  output logic               busy,
  output logic               ir_loaded,
  output logic [15:0]        overrun_count
);

  localparam logic [14:0] LAST_SAMPLE = 15'(4 * MEMORY_DEPTH - 1);
  localparam logic [12:0] HALF        = 13'(MEMORY_DEPTH / 2);
  localparam logic [12:0] HALF_LAST   = 13'(MEMORY_DEPTH / 2 - 1);
  localparam logic [7:0]  DRAIN_LAST  = 8'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LOAD, READY, SWEEP, DRAIN} state_t;

  state_t      state;
  logic [14:0] sample_cnt;
  logic [7:0]  drain_cnt;

  logic        pipe_vld  [READ_LATENCY];
  logic        pipe_last [READ_LATENCY];
  logic [12:0] pipe_idx  [READ_LATENCY];

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      sample_cnt      <= '0;
      drain_cnt       <= '0;
      load_ready      <= 1'b0;
      ir_sample_index <= '0;
      write_data      <= '0;
      write_enable    <= 1'b0;
      first_ir_index  <= '0;
      second_ir_index <= '0;
      busy            <= 1'b0;
      ir_loaded       <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        IDLE, READY: begin
          // load_start outranks a coincident tick, which is simply lost
          if (load_start) begin
            state      <= LOAD;
            sample_cnt <= '0;
            ir_loaded  <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end else if (state == READY && sample_tick) begin
            state           <= SWEEP;
            first_ir_index  <= '0;
            second_ir_index <= HALF;
            busy            <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            sample_cnt <= '0;
            load_ready <= 1'b1;
          end else begin
            if (load_valid && load_ready) begin
              write_enable    <= 1'b1;
              write_data      <= load_data;
              ir_sample_index <= sample_cnt;
              sample_cnt      <= sample_cnt + 15'd1;
              if (sample_cnt == LAST_SAMPLE) load_ready <= 1'b0;
            end
            // leave only once the final sample's write strobe has been issued
            if (write_enable && ir_sample_index == LAST_SAMPLE) begin
              state      <= READY;
              ir_loaded  <= 1'b1;
              load_ready <= 1'b0;
              busy       <= 1'b0;
            end
          end
        end
        SWEEP: begin
          if (first_ir_index == HALF_LAST) begin
            state           <= DRAIN;
            first_ir_index  <= '0;
            second_ir_index <= '0;
            drain_cnt       <= '0;
          end else begin
            first_ir_index  <= first_ir_index + 13'd1;
            second_ir_index <= second_ir_index + 13'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow of the bank read latency: issue flag, address and last-tap marker
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_last[i] <= 1'b0;
        pipe_idx[i]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= (state == SWEEP);
      pipe_last[0] <= (state == SWEEP) && (first_ir_index == HALF_LAST);
      pipe_idx[0]  <= first_ir_index;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
      end
    end
  end

  assign tap_valid  = pipe_vld[READ_LATENCY-1];
  assign tap_index  = pipe_idx[READ_LATENCY-1];
  assign sweep_done = pipe_vld[READ_LATENCY-1] & pipe_last[READ_LATENCY-1];

`ifdef IR_OVERRUN_COUNT_EN
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      overrun_count <= '0;
    end else if ((state == SWEEP || state == DRAIN) && sample_tick &&
                 overrun_count != 16'hFFFF) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_ir_conv_sequencer.sv
// Scoreboard bench for ir_conv_sequencer: random IR loads and sweeps against a queue-based model.
module tb_ir_conv_sequencer;
  localparam int MD   = 8;
  localparam int RL   = 2;
  localparam int HALF = MD / 2;
  localparam int NS   = 4 * MD;

  logic               audio_clk = 1'b0;
  logic               rst_in = 1'b1;
  logic               load_start = 1'b0;
  logic signed [15:0] load_data = '0;
  logic               load_valid = 1'b0;
  logic               load_ready;
  logic               sample_tick = 1'b0;
  logic [14:0]        ir_sample_index;
  logic signed [15:0] write_data;
  logic               write_enable;
  logic [12:0]        first_ir_index;
  logic [12:0]        second_ir_index;
  logic               tap_valid;
  logic [12:0]        tap_index;
  logic               sweep_done;
  logic               busy;
  logic               ir_loaded;
  logic [15:0]        overrun_count;

  ir_conv_sequencer #(.MEMORY_DEPTH(MD), .READ_LATENCY(RL)) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .load_start(load_start),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .sample_tick(sample_tick), .ir_sample_index(ir_sample_index),
    .write_data(write_data), .write_enable(write_enable),
    .first_ir_index(first_ir_index), .second_ir_index(second_ir_index),
    .tap_valid(tap_valid), .tap_index(tap_index), .sweep_done(sweep_done),
    .busy(busy), .ir_loaded(ir_loaded), .overrun_count(overrun_count)
  );

  always #5 audio_clk = ~audio_clk;

  int cyc = 0;
  always @(posedge audio_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ovr = 0;

  typedef struct { int idx; int dat; } wr_t;
  typedef struct { int idx; bit done; int at; } tap_t;
  wr_t  exp_wr[$];
  tap_t exp_tap[$];
  wr_t  ew;
  tap_t et;
  logic signed [15:0] ir_mem [NS];

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_ready"}, load_ready, 0);
    check({tag, "_write_enable"}, write_enable, 0);
    check({tag, "_tap_valid"}, tap_valid, 0);
    check({tag, "_sweep_done"}, sweep_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ir_loaded"}, ir_loaded, 0);
    check({tag, "_ir_sample_index"}, ir_sample_index, 0);
    check({tag, "_write_data"}, write_data, 0);
    check({tag, "_first_ir_index"}, first_ir_index, 0);
    check({tag, "_second_ir_index"}, second_ir_index, 0);
    check({tag, "_tap_index"}, tap_index, 0);
    check({tag, "_overrun_count"}, overrun_count, 0);
  endtask

  // Monitor: every write strobe and every tap must match the head of its queue
  always @(negedge audio_clk) begin
    if (!rst_in) begin
      if (write_enable) begin
        if (exp_wr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: index %0d data %0d, no write expected", ir_sample_index, write_data);
        end else begin
          ew = exp_wr.pop_front();
          check("write_index", ir_sample_index, ew.idx);
          check("write_data", write_data, ew.dat);
        end
      end
      if (tap_valid) begin
        if (exp_tap.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_tap: tap_index %0d at cycle %0d, no tap expected", tap_index, cyc);
        end else begin
          et = exp_tap.pop_front();
          check("tap_index", tap_index, et.idx);
          check("tap_cycle", cyc, et.at);
          check("sweep_done", sweep_done, et.done);
        end
      end else begin
        check("sweep_done_idle", sweep_done, 0);
      end
    end
  end

  task automatic fill_ir(input bit ramp);
    for (int k = 0; k < NS; k++) ir_mem[k] = ramp ? 16'(16'h0100 + k) : 16'($urandom);
  endtask

  // mode 0: valid always, 1: valid every other cycle, 2: random valid with stray ticks
  task automatic do_load(input int mode, input int restart_at, input bit collide);
    int k, guard;
    bit hs, restarted;
    load_start = 1'b1; sample_tick = collide;
    @(posedge audio_clk); #1;
    load_start = 1'b0; sample_tick = 1'b0;
    check("load_entry_busy", busy, 1);
    check("load_entry_ready", load_ready, 1);
    check("load_entry_loaded", ir_loaded, 0);
    k = 0; guard = 0; restarted = 0;
    while (k < NS && guard < 2000) begin
      guard++;
      if (restart_at > 0 && !restarted && k == restart_at) begin
        load_valid = 1'b0; load_start = 1'b1; restarted = 1; k = 0;
        @(posedge audio_clk); #1;
        load_start = 1'b0;
        continue;
      end
      case (mode)
        0: load_valid = 1'b1;
        1: load_valid = (cyc % 2 == 0);
        default: load_valid = ($urandom_range(0, 3) != 0);
      endcase
      load_data = ir_mem[k];
      if (mode == 2) sample_tick = ($urandom_range(0, 7) == 0);
      hs = load_valid && load_ready;
      if (hs) exp_wr.push_back('{k, int'(ir_mem[k])});
      @(posedge audio_clk); #1;
      sample_tick = 1'b0;
      if (hs) k++;
    end
    load_valid = 1'b0;
    if (guard >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL load_timeout: accepted %0d of %0d samples", k, NS);
    end
    check("load_ready_after_last", load_ready, 0);
    check("loaded_during_last_write", ir_loaded, 0);
    @(posedge audio_clk); #1;
    check("ir_loaded", ir_loaded, 1);
    check("load_done_busy", busy, 0);
    check("load_done_ready", load_ready, 0);
  endtask

  // extra_at: busy-window cycle at which a dropped tick is injected (out of range = none)
  task automatic do_sweep(input int extra_at);
    int k0;
    k0 = cyc;
    sample_tick = 1'b1;
    for (int t = 0; t < HALF; t++) exp_tap.push_back('{t, (t == HALF - 1), k0 + 1 + RL + t});
    @(posedge audio_clk); #1;
    sample_tick = 1'b0;
    for (int c = 0; c < HALF + RL; c++) begin
      check("sweep_busy", busy, 1);
      check("first_ir_index", first_ir_index, (c < HALF) ? c : 0);
      check("second_ir_index", second_ir_index, (c < HALF) ? c + HALF : 0);
      check("sweep_write_enable", write_enable, 0);
      if (c == extra_at) begin
        sample_tick = 1'b1;
`ifdef IR_OVERRUN_COUNT_EN
        exp_ovr++;
`endif
      end
      @(posedge audio_clk); #1;
      sample_tick = 1'b0;
    end
    check("sweep_end_busy", busy, 0);
    check("overrun_count", overrun_count, exp_ovr);
  endtask

  task automatic apply_reset_now(input string tag);
    rst_in = 1'b1;
    exp_wr.delete(); exp_tap.delete(); exp_ovr = 0;
    #1;
    check_all_zero(tag);
    @(posedge audio_clk); #1;
    rst_in = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge audio_clk); #1;
    check_all_zero("reset");
    rst_in = 1'b0;
    @(posedge audio_clk); #1;

    fill_ir(1'b1);
    do_load(0, 0, 1'b0);
    do_sweep(-1);
    do_sweep(1);
    do_sweep(HALF);

    fill_ir(1'b0);
    do_load(1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge audio_clk); #1;
        check("ready_idle_busy", busy, 0);
      end
      do_sweep(int'($urandom_range(0, HALF + RL)));
    end

    fill_ir(1'b0);
    do_load(2, 5, 1'b1);
    do_sweep(-1);

    // reset during sweep cycle 2
    sample_tick = 1'b1;
    for (int t = 0; t < HALF; t++) exp_tap.push_back('{t, (t == HALF - 1), cyc + 1 + RL + t});
    @(posedge audio_clk); #1;
    sample_tick = 1'b0;
    repeat (2) @(posedge audio_clk);
    #2;
    apply_reset_now("sweep_rst");
    repeat (3) @(posedge audio_clk); #1;
    sample_tick = 1'b1;
    @(posedge audio_clk); #1;
    sample_tick = 1'b0;
    repeat (6) @(posedge audio_clk); #1;
    check("idle_tick_busy", busy, 0);
    check("idle_tick_loaded", ir_loaded, 0);

    fill_ir(1'b0);
    do_load(0, 0, 1'b0);
    do_sweep(-1);

    // reset after 10 samples of a load
    load_start = 1'b1;
    @(posedge audio_clk); #1;
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      load_valid = 1'b1; load_data = ir_mem[k];
      if (load_ready) exp_wr.push_back('{k, int'(ir_mem[k])});
      @(posedge audio_clk); #1;
    end
    load_valid = 1'b0;
    #2;
    apply_reset_now("load_rst");
    repeat (5) @(posedge audio_clk); #1;
    check("post_load_rst_loaded", ir_loaded, 0);

    fill_ir(1'b0);
    do_load(2, 0, 1'b0);
    do_sweep(0);

    repeat (6) @(posedge audio_clk); #1;
    check("writes_outstanding", exp_wr.size(), 0);
    check("taps_outstanding", exp_tap.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
